// File: rtl/led_pwm_blinker.sv
// LED pin driver: global PWM dimming plus per-LED blink, configured over a 4-word Avalon-MM slave.
// led_in to led_out is 1 clk; zero-wait-state slave with no backpressure.
module led_pwm_blinker #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [7:0]  led_in,
    output logic [7:0]  led_out
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic [15:0] pre_cnt;
    logic [7:0]  pwm_cnt;
    logic [7:0]  bright;
    logic [7:0]  act_bright;
    logic [7:0]  blink_mask;
    logic [15:0] blink_half;
    logic [15:0] blink_cnt;
    logic        blink_phase;

    logic wr;
    logic tick;
    logic frame_end;
    logic pwm_on;
    logic unused_wdata;

    assign wr           = chipselect && !write_n;
    assign tick         = (pre_cnt == DIV_LAST);
    assign frame_end    = tick && (pwm_cnt == 8'd254);
    assign pwm_on       = (pwm_cnt < act_bright);
    assign unused_wdata = ^writedata[31:16];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            act_bright <= 8'hFF;
        end else begin
            if (tick) begin
                pre_cnt <= '0;
                pwm_cnt <= (pwm_cnt == 8'd254) ? 8'd0 : pwm_cnt + 8'd1;
            end else begin
                pre_cnt <= pre_cnt + 16'd1;
            end
            // Duty only changes on a frame boundary so no frame is ever truncated.
            if (frame_end)
                act_bright <= bright;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright     <= 8'hFF;
            blink_mask <= '0;
            blink_half <= '0;
        end else if (wr) begin
            case (address)
                2'd0:    bright     <= writedata[7:0];
                2'd1:    blink_mask <= writedata[7:0];
                2'd2:    blink_half <= writedata[15:0];
                default: ;
            endcase
        end
    end

    // A BLINK_HALF write restarts the blink cycle and takes priority over frame_end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr && address == 2'd2) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (blink_half == 16'd0) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == blink_half - 16'd1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            led_out <= '0;
        else
            led_out <= led_in & {8{pwm_on}} & (~blink_mask | {8{blink_phase}});
    end

    always_comb begin
        readdata = '0;
        if (chipselect) begin
            case (address)
                2'd0:    readdata[7:0]  = bright;
                2'd1:    readdata[7:0]  = blink_mask;
                2'd2:    readdata[15:0] = blink_half;
                default: readdata[15:0] = {pwm_cnt, 7'd0, blink_phase};
            endcase
        end
    end

endmodule

// File: doc/led_pwm_blinker.md
# led_pwm_blinker

Downstream consumer of the 8-bit LED PIO output register. It takes the PIO's `out_port` value on `led_in` and drives the physical LED pins on `led_out`. Each LED is dimmed by a global PWM duty and can optionally blink, with a programmable half-period. Configuration is through its own 4-word Avalon-MM slave (s1) on the same system interconnect, with zero wait states.

## Interface
- `CLK_DIV`, default 50: clk cycles per PWM step. Legal range 1..65535.
- `clk`  in  1  system clock
- `reset_n`  in  1  reset, asynchronous, active-low
- `address`  in  2  word address
- `chipselect`  in  1  slave select
- `write_n`  in  1  active-low write strobe
- `writedata`  in  32  write data
- `readdata`  out  32  combinational read data, zero wait states
- `led_in`  in  8  LED on/off request, from the PIO `out_port`, same clk domain
- `led_out`  out  8  registered LED pin drive, 1 = lit

## Operation
- Register map (write = `chipselect && !write_n`; unused bits read 0):
  - 0 BRIGHT[7:0]: PWM duty, reset 0xFF.
  - 1 BLINK_MASK[7:0]: per-LED blink enable, reset 0x00.
  - 2 BLINK_HALF[15:0]: blink half-period in PWM frames, reset 0x0000. 0 = blinking disabled.
  - 3 STATUS, read-only: [0] `blink_phase`, [15:8] `pwm_cnt`. Writes to it are ignored.
- Prescaler `pre_cnt`, 16 bits:
  - counts 0..CLK_DIV-1, then wraps to 0;
  - `tick` = (`pre_cnt` == CLK_DIV-1).
- PWM counter `pwm_cnt`, 8 bits:
  - advances on `tick` over 0..254, then wraps to 0, giving 255 steps per frame;
  - `frame_end` = `tick` && `pwm_cnt` == 254.
- Active duty `act_bright` is a shadow of BRIGHT:
  - loaded only on `frame_end`, so the duty never changes mid-frame;
  - `pwm_on` = (`pwm_cnt` < `act_bright`);
  - therefore 0x00 = always off and 0xFF = always on.
- Blink:
  - `blink_cnt`, 16 bits, increments on `frame_end`;
  - when it equals BLINK_HALF-1 it clears to 0 and `blink_phase` toggles;
  - while BLINK_HALF == 0, `blink_cnt` is held at 0 and `blink_phase` is held at 1.
- Writing BLINK_HALF sets `blink_cnt` to 0 and `blink_phase` to 1 on the next edge. If the write coincides with `frame_end`, the write wins.
- Next `led_out[i]` = `led_in[i]` & `pwm_on` & (~BLINK_MASK[i] | `blink_phase`).
- Reset values:
  - `led_out` = 0x00, `pre_cnt` = 0, `pwm_cnt` = 0, `blink_cnt` = 0, `blink_phase` = 1;
  - BRIGHT and `act_bright` = 0xFF, BLINK_MASK = 0, BLINK_HALF = 0.
- `readdata`:
  - combinational function of `address`, valid whenever `chipselect` is high;
  - returns the programmed BRIGHT, not `act_bright`.

## Timing
- `led_in` to `led_out` latency is 1 clk, provided `pwm_on` and blink permit.
- A BRIGHT write takes effect at the first `frame_end` strictly after the write edge. Worst case is 255*CLK_DIV cycles.
- A BLINK_MASK write affects `led_out` 2 clk after the write cycle: 1 edge for the register, 1 edge for the output.
- Frame period is 255*CLK_DIV clk. A full blink cycle is 2*BLINK_HALF frames.
- Reset assertion forces every register to its reset value asynchronously, so `led_out` goes to 0x00 immediately. After deassertion, the counters restart from 0 on the first clk edge.
- No handshake and no backpressure: Avalon reads and writes complete in the cycle `chipselect` is seen.

## Test plan
All scenarios use CLK_DIV = 2, so a frame is 510 clk.
1. After reset, drive `led_in` = 0xA5 with defaults → `led_out` = 0xA5 from the 1st edge after `led_in` changes and stays constant. Reads of regs 0/1/2 return 0xFF/0x00/0x0000.
2. Write BRIGHT = 0x80 mid-frame → the old duty (fully on) holds until `frame_end`. Each following frame has `led_out` = 0xA5 for 256 clk, then 0x00 for 254 clk. A read of reg 0 returns 0x80 immediately.
3. Write BRIGHT = 0x00 → from the next frame boundary `led_out` = 0x00 continuously, while STATUS[15:8] keeps counting 0..254.
4. With BRIGHT = 0xFF, `led_in` = 0xFF, BLINK_MASK = 0x0F, BLINK_HALF = 2 → `led_out` alternates 0xFF for 2 frames and 0xF0 for 2 frames. STATUS[0] toggles every 1020 clk.
5. Write BLINK_HALF during the 0xF0 phase, in the same cycle as `frame_end` → the next edge gives `blink_phase` = 1 and `blink_cnt` = 0, so `led_out` returns to 0xFF. Then write BLINK_HALF = 0 → `led_out` stays 0xFF.
6. Pull `reset_n` low mid-blink and mid-frame → `led_out` = 0x00 without a clk edge. After release: all registers read their defaults and `led_out` = `led_in` 1 edge later.
